// File: rtl/piso_stream_if.sv
// piso_stream_if: word-in / bit-out bundle for piso_stream.
//   d, in_valid, in_ready : parallel word handshake (accept = in_valid & in_ready)
//   shift_en              : bit-rate enable
//   y, y_valid            : serial data and its qualifier
//   y_first, y_last, done : framing markers and end-of-stream pulse
// master = word source / bit sink, slave = the shifter.
interface piso_stream_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] d;
  logic             in_valid;
  logic             in_ready;
  logic             shift_en;
  logic             y;
  logic             y_valid;
  logic             y_first;
  logic             y_last;
  logic             done;

  modport master (
    output d, in_valid, shift_en,
    input  in_ready, y, y_valid, y_first, y_last, done
  );

  modport slave (
    input  d, in_valid, shift_en,
    output in_ready, y, y_valid, y_first, y_last, done
  );
endinterface

// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out shifter with a one-word holding buffer.
//   clk : rising-edge clock
//   res : asynchronous active-high reset
//   s   : piso_stream_if slave (word handshake in, paced serial bit stream out)
// Words are serialised MSB- or LSB-first; bits advance only on shift_en edges.
// The holding buffer lets the next word follow the last bit with no gap cycle.
module piso_stream #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input logic           clk,
  input logic           res,
  piso_stream_if.slave  s
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state,     w_state;
  logic [WIDTH-1:0] r_shreg,     w_shreg;
  logic [CW-1:0]    r_cnt,       w_cnt;
  logic [WIDTH-1:0] r_hold,      w_hold;
  logic             r_hold_full, w_hold_full;
  logic             r_y,         w_y;
  logic             r_y_valid,   w_y_valid;
  logic             r_y_first,   w_y_first;
  logic             r_y_last,    w_y_last;
  logic             r_done,      w_done;
  logic             w_accept;
  logic             w_direct;

  // Ready depends only on the holding-buffer flag, never on in_valid.
  assign w_accept   = s.in_valid & ~r_hold_full;
  assign s.in_ready = ~r_hold_full;
  assign s.y        = r_y;
  assign s.y_valid  = r_y_valid;
  assign s.y_first  = r_y_first;
  assign s.y_last   = r_y_last;
  assign s.done     = r_done;

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_y         <= IDLE_LEVEL;
      r_y_valid   <= 1'b0;
      r_y_first   <= 1'b0;
      r_y_last    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_shreg     <= w_shreg;
      r_cnt       <= w_cnt;
      r_hold      <= w_hold;
      r_hold_full <= w_hold_full;
      r_y         <= w_y;
      r_y_valid   <= w_y_valid;
      r_y_first   <= w_y_first;
      r_y_last    <= w_y_last;
      r_done      <= w_done;
    end
  end

  // Next-state, accept routing and next-output decode.
  always_comb begin
    w_state     = r_state;
    w_shreg     = r_shreg;
    w_cnt       = r_cnt;
    w_hold      = r_hold;
    w_hold_full = r_hold_full;
    w_done      = 1'b0;
    w_direct    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shreg  = s.d;
          w_cnt    = '0;
          w_state  = S_SHIFT;
          w_direct = 1'b1;
        end
      end
      S_SHIFT: begin
        if (s.shift_en) begin
          if (r_cnt == LAST_IDX) begin
            // Last bit consumed: refill from hold, then from input, else stop.
            if (r_hold_full) begin
              w_shreg     = r_hold;
              w_cnt       = '0;
              w_hold_full = 1'b0;
            end else if (w_accept) begin
              w_shreg  = s.d;
              w_cnt    = '0;
              w_direct = 1'b1;
            end else begin
              w_state = S_IDLE;
              w_done  = 1'b1;
            end
          end else begin
            w_shreg = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                : {1'b0, r_shreg[WIDTH-1:1]};
            w_cnt   = r_cnt + CW'(1);
          end
        end
      end
    endcase

    // An accepted word that did not go straight into the shifter is parked.
    if (w_accept && !w_direct) begin
      w_hold      = s.d;
      w_hold_full = 1'b1;
    end

    w_y_valid = (w_state == S_SHIFT);
    w_y       = w_y_valid ? (MSB_FIRST ? w_shreg[WIDTH-1] : w_shreg[0]) : IDLE_LEVEL;
    w_y_first = w_y_valid && (w_cnt == '0);
    w_y_last  = w_y_valid && (w_cnt == LAST_IDX);
  end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: three instances (4-bit MSB-first, 4-bit LSB-first,
// 8-bit MSB-first idling high), directed sequences plus randomized traffic
// against a word/bit-index reference model.
// Observation vector order: {y, y_valid, y_first, y_last, done, in_ready}.
module tb_piso_stream;

  logic clk;
  logic res;
  int   n_checks;
  int   n_errors;

  piso_stream_if #(.WIDTH(4)) if_a();
  piso_stream_if #(.WIDTH(4)) if_b();
  piso_stream_if #(.WIDTH(8)) if_c();

  piso_stream #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .res(res), .s(if_a.slave));
  piso_stream #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
    .clk(clk), .res(res), .s(if_b.slave));
  piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_c (
    .clk(clk), .res(res), .s(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_w(input int sel);
    return (sel == 2) ? 8 : 4;
  endfunction

  function automatic bit cfg_msb(input int sel);
    return sel != 1;
  endfunction

  function automatic logic cfg_idle(input int sel);
    return (sel == 2) ? 1'b1 : 1'b0;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] dw, input logic sen);
    case (sel)
      0: begin if_a.in_valid = v; if_a.d = 4'(dw); if_a.shift_en = sen; end
      1: begin if_b.in_valid = v; if_b.d = 4'(dw); if_b.shift_en = sen; end
      default: begin if_c.in_valid = v; if_c.d = 8'(dw); if_c.shift_en = sen; end
    endcase
  endtask

  function automatic logic [5:0] obs(input int sel);
    case (sel)
      0: return {if_a.y, if_a.y_valid, if_a.y_first, if_a.y_last, if_a.done, if_a.in_ready};
      1: return {if_b.y, if_b.y_valid, if_b.y_first, if_b.y_last, if_b.done, if_b.in_ready};
      default: return {if_c.y, if_c.y_valid, if_c.y_first, if_c.y_last, if_c.done, if_c.in_ready};
    endcase
  endfunction

  // Reference model: current word + bit index, and an optional queued word.
  bit          m_active;
  int          m_idx;
  logic [31:0] m_cur;
  logic [31:0] m_hold;
  bit          m_hold_full;
  logic [5:0]  m_exp;

  task automatic model_reset(input int sel);
    m_active    = 1'b0;
    m_idx       = 0;
    m_cur       = '0;
    m_hold      = '0;
    m_hold_full = 1'b0;
    m_exp       = {cfg_idle(sel), 5'b00001};
  endtask

  task automatic model_edge(input int sel, input logic v, input logic [31:0] dw, input logic sen);
    int   w;
    bit   acc;
    logic dn;
    logic bitv;
    w   = cfg_w(sel);
    acc = v && !m_hold_full;
    dn  = 1'b0;
    if (m_active) begin
      if (sen) begin
        if (m_idx == w - 1) begin
          if (m_hold_full) begin
            m_cur = m_hold; m_idx = 0; m_hold_full = 1'b0;
          end else if (acc) begin
            m_cur = dw; m_idx = 0; acc = 1'b0;
          end else begin
            m_active = 1'b0; dn = 1'b1;
          end
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end else if (acc) begin
      m_cur = dw; m_idx = 0; m_active = 1'b1; acc = 1'b0;
    end
    if (acc) begin
      m_hold = dw; m_hold_full = 1'b1;
    end
    bitv  = cfg_msb(sel) ? m_cur[w-1-m_idx] : m_cur[m_idx];
    m_exp = m_active ? {bitv, 1'b1, m_idx == 0, m_idx == w - 1, dn, !m_hold_full}
                     : {cfg_idle(sel), 1'b0, 1'b0, 1'b0, dn, !m_hold_full};
  endtask

  task automatic do_reset();
    res = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got, exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      got = obs(i);
      exp = {cfg_idle(i), 5'b00001};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reset dut=%0d got %b exp %b", i, got, exp);
      end
    end
  endtask

  // One word, shift_en held high; expected bit order written out literally.
  task automatic test_single_word(input int sel);
    logic [7:0] word, seq;
    logic [5:0] got, exp;
    int w;
    logic idle;
    w    = cfg_w(sel);
    idle = cfg_idle(sel);
    case (sel)
      0: begin word = 8'h09; seq = 8'b1001_0000; end
      1: begin word = 8'h0A; seq = 8'b0101_0000; end
      default: begin word = 8'hA5; seq = 8'b1010_0101; end
    endcase
    drive(sel, 1'b1, {24'h0, word}, 1'b1);
    for (int k = 0; k <= w + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) drive(sel, 1'b0, '0, 1'b1);
      exp = (k < w) ? {seq[7-k], 1'b1, k == 0, k == w - 1, 1'b0, 1'b1}
                    : {idle, 1'b0, 1'b0, 1'b0, k == w, 1'b1};
      got = obs(sel);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL single_word dut=%0d k=%0d got %b exp %b", sel, k, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    logic [5:0] got, exp;
    logic rdy;
    seq = 8'b1001_1010;
    drive(0, 1'b1, 32'h9, 1'b1);
    for (int k = 0; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) drive(0, 1'b1, 32'hA, 1'b1);
      else        drive(0, 1'b0, '0, 1'b1);
      rdy = !(k >= 1 && k <= 3);
      exp = (k < 8) ? {seq[7-k], 1'b1, k == 0 || k == 4, k == 3 || k == 7, 1'b0, rdy}
                    : {1'b0, 1'b0, 1'b0, 1'b0, k == 8, 1'b1};
      got = obs(0);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL back_to_back k=%0d got %b exp %b", k, got, exp);
      end
    end
  endtask

  // shift_en every third edge: each bit must be held for three cycles.
  task automatic test_paced();
    logic [3:0] seq;
    logic [5:0] got, exp;
    int valid_cnt;
    int b;
    seq = 4'b1100;
    valid_cnt = 0;
    drive(0, 1'b1, 32'hC, 1'b0);
    for (int t = 0; t <= 14; t++) begin
      @(posedge clk);
      #1;
      drive(0, 1'b0, '0, ((t + 1) % 3) == 0);
      b = t / 3;
      exp = (t < 12) ? {seq[3-b], 1'b1, b == 0, b == 3, 1'b0, 1'b1}
                     : {1'b0, 1'b0, 1'b0, 1'b0, t == 12, 1'b1};
      got = obs(0);
      if (got[4]) valid_cnt++;
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL paced t=%0d got %b exp %b", t, got, exp);
      end
    end
    n_checks++;
    if (valid_cnt != 12) begin
      n_errors++;
      $display("FAIL paced_valid_cycles got %0d exp 12", valid_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seq;
    logic [5:0] got, exp;
    drive(0, 1'b1, 32'h9, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 32'hA, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, '0, 1'b1);
    got = obs(0);
    exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL reset_mid_pre got %b exp %b", got, exp);
    end
    res = 1'b1;
    #2;
    got = obs(0);
    exp = 6'b000001;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL reset_mid_async got %b exp %b", got, exp);
    end
    @(posedge clk);
    #1;
    got = obs(0);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL reset_mid_next got %b exp %b", got, exp);
    end
    res = 1'b0;
    seq = 4'b0110;
    drive(0, 1'b1, 32'h6, 1'b1);
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) drive(0, 1'b0, '0, 1'b1);
      exp = (k < 4) ? {seq[3-k], 1'b1, k == 0, k == 3, 1'b0, 1'b1}
                    : {1'b0, 1'b0, 1'b0, 1'b0, k == 4, 1'b1};
      got = obs(0);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reset_mid_fresh k=%0d got %b exp %b", k, got, exp);
      end
    end
  endtask

  task automatic test_random(input int sel);
    logic        v, sen;
    logic [31:0] dw;
    logic [5:0]  got;
    int          n;
    do_reset();
    model_reset(sel);
    n = 400 + 2 * cfg_w(sel) + 4;
    for (int c = 0; c < n; c++) begin
      if (c < 400) begin
        v   = 1'($urandom_range(0, 1));
        dw  = $urandom;
        sen = ($urandom_range(0, 3) != 0);
      end else begin
        v   = 1'b0;
        dw  = '0;
        sen = 1'b1;
      end
      drive(sel, v, dw, sen);
      @(posedge clk);
      model_edge(sel, v, dw, sen);
      #1;
      got = obs(sel);
      n_checks++;
      if (got !== m_exp) begin
        n_errors++;
        $display("FAIL random dut=%0d cycle=%0d got %b exp %b", sel, c, got, m_exp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    res = 1'b1;
    test_reset();
    test_single_word(0);
    test_single_word(1);
    test_single_word(2);
    test_back_to_back();
    test_paced();
    test_reset_mid();
    test_random(0);
    test_random(1);
    test_random(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out shifter. Successor to the fixed 4-bit load/shift register.
- Accepts WIDTH-bit words over a valid/ready handshake and serialises them MSB- or LSB-first on a single-bit output.
- Shifting is paced by a bit-rate enable. A one-word holding buffer allows gap-free back-to-back frames.
- Sits between word-wide datapath logic and serial links (SPI-style TX, shift-register chains).

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 0, value driven on y when no word is being shifted.

Ports:
- clk  input  1  rising-edge clock.
- res  input  1  asynchronous active-high reset.
- d  input  WIDTH  parallel word in.
- in_valid  input  1  d is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  bit-rate enable; the current bit advances only on edges where this is 1.
- y  output  1  serial data out (registered).
- y_valid  output  1  y carries a data bit.
- y_first  output  1  y is the first bit of a word.
- y_last  output  1  y is the last bit of a word.
- done  output  1  one-cycle pulse after the last bit of a word is consumed with no next word queued.

Behaviour:
- Reset (async, any time, including mid-word):
  - y=IDLE_LEVEL; y_valid, y_first, y_last, done = 0; in_ready=1.
  - Shifter and holding buffer emptied; bit counter = 0.
  - Any word in flight is discarded.
- State machine: IDLE (shifter empty) and SHIFT (shifter holds a word).
  - Holding buffer: 1 entry, independent full flag.
- Handshake:
  - Accept occurs on a rising edge with in_valid & in_ready.
  - in_ready = !hold_full. It depends only on registered state, never on in_valid.
  - d is ignored when not accepted.
- Accept routing:
  - IDLE, hold empty: word loads directly into the shifter → SHIFT. The first bit appears on y in the next cycle, i.e. 1 edge of latency, with y_first=1.
  - SHIFT, not finishing: word goes to the hold buffer; in_ready drops the next cycle.
  - SHIFT, finishing this edge, hold empty: word loads directly into the shifter with no gap cycle.
- Shifting:
  - In SHIFT, y holds the current bit until an edge with shift_en=1. That edge advances to the next bit and increments the counter.
  - shift_en is ignored in IDLE.
- Bit order:
  - MSB_FIRST=1: sequence d[WIDTH-1] … d[0].
  - MSB_FIRST=0: sequence d[0] … d[WIDTH-1].
- Finishing = shift_en edge while counter == WIDTH-1. On that edge:
  - Hold full: hold → shifter, hold cleared, stay in SHIFT. y_first=1 next cycle; no gap; done not pulsed.
  - Hold empty and accept: direct load as above; done not pulsed.
  - Hold empty, no accept: → IDLE. y=IDLE_LEVEL and y_valid=0 next cycle; done=1 for exactly one cycle.
- Flags:
  - y_valid=1 exactly while in SHIFT.
  - y_first=1 while bit index 0 is presented; y_last=1 while bit index WIDTH-1 is presented.
- The counter wraps to 0 on each new word. Width is clog2(WIDTH), with one bit minimum.
- Only res clears the hold buffer; there is no other flush path.

Test Plan:
- WIDTH=4, MSB_FIRST=1, shift_en tied 1. Accept d=4'b1001 at edge N → y = 1,0,0,1 in cycles N+1..N+4. y_first in N+1 only, y_last in N+4 only. done=1 in N+5; y_valid=0, y=0 from N+5.
- MSB_FIRST=0, d=4'b1010 → y = 0,1,0,1.
- Back-to-back: accept 4'b1001, then 4'b1010 while shifting. in_ready=0 until hold drains. y = 1,0,0,1,1,0,1,0 with no gap; y_first at bits 1 and 5; single done at the end.
- shift_en high every 3rd cycle, d=4'b1100 → each bit held 3 cycles; total 12 cycles with y_valid=1.
- Assert res during the 2nd bit with the hold buffer full → next cycle y=IDLE_LEVEL, y_valid=0, in_ready=1, no done pulse. A fresh word 4'b0110 then serialises correctly.
- WIDTH=8, IDLE_LEVEL=1: idle y=1. Send 8'hA5 MSB-first → 1,0,1,0,0,1,0,1, then y returns to 1.
